// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 8-digit display scanner.
package display_pkg;

  localparam int unsigned NumDigits = 8;
  localparam int unsigned DigitW    = $clog2(NumDigits);

  typedef enum logic {
    StBlank,
    StShow
  } scan_state_e;

  // One complete set of per-digit display settings, as captured on load_i.
  typedef struct packed {
    logic [4*NumDigits-1:0] data;
    logic [NumDigits-1:0]   ltr;
    logic [NumDigits-1:0]   dp;
    logic [NumDigits-1:0]   en;
  } disp_cfg_t;

endpackage

// File: rtl/display_decoder.sv
// Nibble to active-low seven-segment glyph; bit 0 (dp) is always returned off.
module display_decoder (
  input  logic [3:0] data_i,
  input  logic       ltr_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = 8'hFF;
    if (!ltr_i) begin
      case (data_i)
        4'd0:    seg_o = {7'b0000001, 1'b1};
        4'd1:    seg_o = {7'b1001111, 1'b1};
        4'd2:    seg_o = {7'b0010010, 1'b1};
        4'd3:    seg_o = {7'b0000110, 1'b1};
        4'd4:    seg_o = {7'b1001100, 1'b1};
        4'd5:    seg_o = {7'b0100100, 1'b1};
        4'd6:    seg_o = {7'b1100000, 1'b1};
        4'd7:    seg_o = {7'b0001111, 1'b1};
        4'd8:    seg_o = {7'b0000000, 1'b1};
        4'd9:    seg_o = {7'b0001100, 1'b1};
        default: seg_o = 8'hFF;
      endcase
    end else begin
      case (data_i)
        4'd5:    seg_o = {7'b1001000, 1'b1};  // H
        4'd10:   seg_o = {7'b1001111, 1'b1};  // I
        default: seg_o = 8'hFF;
      endcase
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 8-digit scanner: blanking gap then lit slot per digit,
// with frame-synchronous update of the displayed values.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned SHOW_CYC  = 100000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_i,
  input  logic [7:0]  ltr_i,
  input  logic [7:0]  dp_i,
  input  logic [7:0]  en_i,
  input  logic        load_i,
  output logic [7:0]  an_o,
  output logic [7:0]  seg_o,
  output logic        frame_o
);

  localparam int unsigned MaxCyc = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam logic [CntW-1:0]   ShowLoad  = CntW'(SHOW_CYC - 1);
  localparam logic [CntW-1:0]   BlankLoad = CntW'(BLANK_CYC - 1);
  localparam logic [DigitW-1:0] LastDigit = DigitW'(NumDigits - 1);

  scan_state_e       state_q, state_d;
  logic [DigitW-1:0] digit_q, digit_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  disp_cfg_t         disp_q, disp_d, pend_q, pend_d, cfg_in;
  logic              pend_vld_q, pend_vld_d;
  logic [7:0]        an_q, an_d, seg_q, seg_d;
  logic              frame_q, frame_d;
  logic              expire, frame_start;
  logic [3:0]        nib;
  logic [7:0]        glyph;

  assign nib = disp_q.data[{digit_q, 2'b00} +: 4];

  display_decoder u_decoder (
    .data_i (nib),
    .ltr_i  (disp_q.ltr[digit_q]),
    .seg_o  (glyph)
  );

  always_comb begin
    cfg_in.data = data_i;
    cfg_in.ltr  = ltr_i;
    cfg_in.dp   = dp_i;
    cfg_in.en   = en_i;

    state_d     = state_q;
    digit_d     = digit_q;
    cnt_d       = cnt_q - CntW'(1);
    expire      = (cnt_q == '0);
    frame_start = expire && (state_q == StShow) && (digit_q == LastDigit);

    if (expire) begin
      unique case (state_q)
        StBlank: begin
          state_d = StShow;
          cnt_d   = ShowLoad;
        end
        StShow: begin
          state_d = StBlank;
          digit_d = digit_q + DigitW'(1);
          cnt_d   = BlankLoad;
        end
        default: state_d = StBlank;
      endcase
    end

    // Pending is consumed before a same-cycle load refills it.
    disp_d     = (frame_start && pend_vld_q) ? pend_q : disp_q;
    pend_d     = load_i ? cfg_in : pend_q;
    pend_vld_d = load_i || (pend_vld_q && !frame_start);

    an_d    = 8'hFF;
    seg_d   = 8'hFF;
    frame_d = frame_start;
    if (state_q == StShow) begin
      seg_d = {glyph[7:1], glyph[0] & ~disp_q.dp[digit_q]};
      if (disp_q.en[digit_q]) an_d[digit_q] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StBlank;
      digit_q    <= '0;
      cnt_q      <= BlankLoad;
      disp_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      an_q       <= 8'hFF;
      seg_q      <= 8'hFF;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      frame_q    <= frame_d;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized and directed bench for display_scan_ctrl against a slot-arithmetic model.
module tb_display_scan_ctrl;

  localparam int unsigned ShowCyc  = 4;
  localparam int unsigned BlankCyc = 2;
  localparam int unsigned Slot     = ShowCyc + BlankCyc;
  localparam int unsigned Frame    = 8 * Slot;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = '0;
  logic [7:0]  ltr = '0, dp = '0, en = '0;
  logic        load = 1'b0;
  logic [7:0]  an, seg;
  logic        frame;

  int total = 0;
  int bad   = 0;

  display_scan_ctrl #(
    .SHOW_CYC  (ShowCyc),
    .BLANK_CYC (BlankCyc)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .data_i  (data),
    .ltr_i   (ltr),
    .dp_i    (dp),
    .en_i    (en),
    .load_i  (load),
    .an_o    (an),
    .seg_o   (seg),
    .frame_o (frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n, input logic l);
    if (l) return (n == 4'd5) ? 7'b1001000 : (n == 4'd10) ? 7'b1001111 : 7'b1111111;
    case (n)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b1100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0001100;
      default: return 7'b1111111;
    endcase
  endfunction

  // Model: position in frame is elapsed cycles since reset modulo the frame length.
  int          s;
  logic [31:0] m_data, p_data;
  logic [7:0]  m_ltr, m_dp, m_en, p_ltr, p_dp, p_en;
  logic        p_vld;
  logic [7:0]  exp_an = 8'hFF, exp_seg = 8'hFF;
  logic        exp_frame = 1'b0;

  always @(posedge clk or posedge rst) begin
    int p, dig;
    bit show;
    if (rst) begin
      s = 0;
      m_data = '0; m_ltr = '0; m_dp = '0; m_en = '0;
      p_data = '0; p_ltr = '0; p_dp = '0; p_en = '0; p_vld = 1'b0;
      exp_an = 8'hFF; exp_seg = 8'hFF; exp_frame = 1'b0;
    end else begin
      p    = s % Frame;
      dig  = p / Slot;
      show = (p % Slot) >= BlankCyc;
      exp_an    = (show && m_en[dig]) ? ~(8'b1 << dig) : 8'hFF;
      exp_seg   = show ? {glyph(m_data[dig*4 +: 4], m_ltr[dig]), ~m_dp[dig]} : 8'hFF;
      exp_frame = (p == Frame - 1);
      if (p == Frame - 1 && p_vld) begin
        m_data = p_data; m_ltr = p_ltr; m_dp = p_dp; m_en = p_en;
        p_vld = 1'b0;
      end
      if (load) begin
        p_data = data; p_ltr = ltr; p_dp = dp; p_en = en; p_vld = 1'b1;
      end
      s++;
    end
  end

  always @(negedge clk) begin
    check("an", an, exp_an);
    check("seg", seg, exp_seg);
    check("frame", {7'b0, frame}, {7'b0, exp_frame});
  end

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame && n < 200);
    if (!frame) begin
      bad++;
      total++;
      $display("FAIL frame_timeout: got no frame_o within %0d cycles, required one", n);
    end
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] l, input logic [7:0] p,
                         input logic [7:0] e);
    data = d; ltr = l; dp = p; en = e; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int n;
    skip(3);
    rst = 1'b0;

    // Free-running dark scan
    wait_frame(n);
    check("first_frame_len", 8'(n), 8'd48);
    wait_frame(n);
    check("frame_len", 8'(n), 8'd48);

    // Plain digits
    do_load(32'h76543210, 8'h00, 8'h00, 8'hFF);
    wait_frame(n);
    skip(3);
    check("d0_an", an, 8'hFE);
    check("d0_seg", seg, 8'b00000011);
    skip(18);
    check("d3_an", an, 8'hF7);
    check("d3_seg", seg, 8'b00001101);

    // Letters and decimal point
    do_load(32'h000000A5, 8'h03, 8'h01, 8'hFF);
    wait_frame(n);
    skip(3);
    check("h_an", an, 8'hFE);
    check("h_seg", seg, 8'b10010000);
    skip(6);
    check("i_an", an, 8'hFD);
    check("i_seg", seg, 8'b10011111);

    // Disabled upper digits keep their slots
    do_load(32'h12345678, 8'h00, 8'h00, 8'h0F);
    wait_frame(n);
    skip(27);
    check("d4_dark", an, 8'hFF);
    wait_frame(n);
    wait_frame(n);
    check("en_frame_len", 8'(n), 8'd48);

    // Double load mid-frame: last one wins at next frame
    skip(10);
    do_load(32'h11111111, 8'h00, 8'h00, 8'hFF);
    skip(4);
    do_load(32'h22222222, 8'h00, 8'h00, 8'hFF);
    wait_frame(n);
    skip(3);
    check("b_an", an, 8'hFE);
    check("b_seg", seg, 8'b00100101);

    // Random loads
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(15) == 0)
        do_load($urandom, 8'($urandom), 8'($urandom), 8'($urandom));
      else
        @(negedge clk);
    end

    // Reset during SHOW of digit 5
    do_load(32'h88888888, 8'h00, 8'h00, 8'hFF);
    wait_frame(n);
    skip(33);
    check("d5_an", an, 8'hDF);
    #2 rst = 1'b1;
    #1;
    check("rst_an", an, 8'hFF);
    check("rst_seg", seg, 8'hFF);
    check("rst_frame", {7'b0, frame}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    skip(3);
    check("post_rst_dark", an, 8'hFF);
    wait_frame(n);
    check("post_rst_len", 8'(n), 8'd45);
    skip(3);
    check("post_rst_d0_dark", an, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
